// File: rtl/seg_display_arbiter_pkg.sv
// seg_arb_pkg: shared types and constants for the seven-segment display arbiter.
//   ST_*     : FSM encodings; owning states double as the one-hot owner code
//   REQ_*    : requester indices (0 = CPU MMIO, 1 = debug source)
//   SEG_DW   : display word width (8 nibbles)
package seg_arb_pkg;

    localparam int SEG_DW  = 32;
    localparam int NUM_REQ = 2;
    localparam int REQ_CPU = 0;
    localparam int REQ_DBG = 1;

    // ST_OWN0/ST_OWN1 are chosen so the state value is the {own1, own0} code.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              vld;
        logic [SEG_DW-1:0] data;
    } seg_req_t;

endpackage

// File: rtl/seg_display_arbiter_req_slot.sv
// seg_req_slot: one-entry shadow for a requester that lost the display.
//   clk, rst : clock, async active-high reset
//   set      : capture data into the shadow and mark it pending
//   clr      : discard the pending entry (it was displayed or superseded)
//   data     : requester display word
//   pend     : shadow holds a value not yet displayed
//   shadow   : captured display word
//   drop     : registered one-cycle pulse, a pending value was overwritten
module seg_req_slot
    import seg_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic              clr,
    input  logic [SEG_DW-1:0] data,
    output logic              pend,
    output logic [SEG_DW-1:0] shadow,
    output logic              drop
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= 1'b0;
            shadow <= '0;
            drop   <= 1'b0;
        end else begin
            drop <= set & pend & ~clr;
            if (clr) begin
                pend <= 1'b0;
            end else if (set) begin
                pend   <= 1'b1;
                shadow <= data;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: time-sliced ownership of the 8-digit display between
// the CPU store path (req0, priority) and a debug source (req1).
//   clk, rst        : clock, async active-high reset
//   req0/data0      : CPU write strobe and display word
//   req1/data1      : debug write strobe and display word
//   seg_we/seg_wdata: registered write pulse/data to the display block
//   owner           : one-hot {own1, own0}, 2'b00 when idle
//   drop            : pulse when a pending shadow value is overwritten
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [SEG_DW-1:0] data0,
    input  logic              req1,
    input  logic [SEG_DW-1:0] data1,
    output logic              seg_we,
    output logic [SEG_DW-1:0] seg_wdata,
    output logic [1:0]        owner,
    output logic              drop
);

    localparam int               CNT_W  = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_d;
    logic [SEG_DW-1:0] wdata_d;

    seg_req_t [NUM_REQ-1:0]              rq;
    logic     [NUM_REQ-1:0]              set, clr, pend, slot_drop;
    logic     [NUM_REQ-1:0][SEG_DW-1:0]  shadow;
    logic                                oi, oj;

    assign rq[REQ_CPU] = '{vld: req0, data: data0};
    assign rq[REQ_DBG] = '{vld: req1, data: data1};

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
            seg_req_slot u_slot (
                .clk    (clk),
                .rst    (rst),
                .set    (set[g]),
                .clr    (clr[g]),
                .data   (rq[g].data),
                .pend   (pend[g]),
                .shadow (shadow[g]),
                .drop   (slot_drop[g])
            );
        end
    endgenerate

    // Current owner index and the other requester; only meaningful in OWN states.
    assign oi = (state_q == ST_OWN1);
    assign oj = ~oi;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        wdata_d = seg_wdata;
        set     = '0;
        clr     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (rq[REQ_CPU].vld) begin
                    state_d      = ST_OWN0;
                    we_d         = 1'b1;
                    wdata_d      = rq[REQ_CPU].data;
                    cnt_d        = RELOAD;
                    set[REQ_DBG] = rq[REQ_DBG].vld;
                end else if (rq[REQ_DBG].vld) begin
                    state_d = ST_OWN1;
                    we_d    = 1'b1;
                    wdata_d = rq[REQ_DBG].data;
                    cnt_d   = RELOAD;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (rq[oi].vld) begin
                    // Owner refresh beats expiry; a loser strobe is shadowed.
                    we_d    = 1'b1;
                    wdata_d = rq[oi].data;
                    cnt_d   = RELOAD;
                    set[oj] = rq[oj].vld;
                end else if (cnt_q != '0) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    set[oj] = rq[oj].vld;
                end else if (rq[oj].vld) begin
                    // Expiry with a live strobe: newest value wins over the shadow.
                    state_d = oj ? ST_OWN1 : ST_OWN0;
                    we_d    = 1'b1;
                    wdata_d = rq[oj].data;
                    cnt_d   = RELOAD;
                    clr[oj] = 1'b1;
                end else if (pend[oj]) begin
                    state_d = oj ? ST_OWN1 : ST_OWN0;
                    we_d    = 1'b1;
                    wdata_d = shadow[oj];
                    cnt_d   = RELOAD;
                    clr[oj] = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            seg_we    <= 1'b0;
            seg_wdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seg_we    <= we_d;
            seg_wdata <= wdata_d;
        end
    end

    assign owner = state_q;
    assign drop  = |slot_drop;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with HOLD_CYCLES=4. Inputs change
// 1ns after a rising edge and outputs are checked at that same point.
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] data0, data1;
    logic        seg_we, drop;
    logic [31:0] seg_wdata;
    logic [1:0]  owner;

    int n_chk  = 0;
    int n_fail = 0;

    seg_display_arbiter #(.HOLD_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .req1      (req1),
        .data1     (data1),
        .seg_we    (seg_we),
        .seg_wdata (seg_wdata),
        .owner     (owner),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock with the given request strobes, then strobes drop.
    task automatic cyc(input logic r0, input logic [31:0] d0,
                       input logic r1, input logic [31:0] d1);
        req0 = r0; data0 = d0; req1 = r1; data1 = d1;
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
    endtask

    task automatic out(input string tag, input logic we, input logic [31:0] wd,
                       input logic [1:0] own, input logic dr);
        chk({tag, ".we"},    32'(seg_we),    32'(we));
        chk({tag, ".wdata"}, seg_wdata,      wd);
        chk({tag, ".owner"}, 32'(owner),     32'(own));
        chk({tag, ".drop"},  32'(drop),      32'(dr));
    endtask

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; data0 = 0; data1 = 0;
        repeat (2) @(posedge clk);
        #1;
        out("reset", 0, 0, 2'b00, 0);
        rst = 1'b0;
        idle(2);
        out("post_rst", 0, 0, 2'b00, 0);

        // Single write, ownership lasts 4 cycles
        cyc(1, 32'h12345678, 0, 0);
        out("single_w", 1, 32'h12345678, 2'b01, 0);
        idle(1);
        out("single_hold", 0, 32'h12345678, 2'b01, 0);
        idle(2);
        chk("single_e3.owner", 32'(owner), 32'h1);
        idle(1);
        out("single_exp", 0, 32'h12345678, 2'b00, 0);

        // Collision: req1 during OWN0 is deferred to expiry
        cyc(1, 32'h00001000, 0, 0);
        cyc(0, 0, 1, 32'hDEAD0001);
        out("coll_defer", 0, 32'h00001000, 2'b01, 0);
        idle(2);
        chk("coll_e3.we", 32'(seg_we), 0);
        idle(1);
        out("coll_exp", 1, 32'hDEAD0001, 2'b10, 0);
        idle(3);
        chk("coll_own1.owner", 32'(owner), 32'h2);
        idle(1);
        out("coll_idle", 0, 32'hDEAD0001, 2'b00, 0);

        // Simultaneous requests in IDLE
        cyc(1, 32'h00000011, 1, 32'h00000022);
        out("simul_w0", 1, 32'h00000011, 2'b01, 0);
        idle(3);
        chk("simul_e3.we", 32'(seg_we), 0);
        idle(1);
        out("simul_w1", 1, 32'h00000022, 2'b10, 0);
        idle(4);
        chk("simul_idle.owner", 32'(owner), 0);

        // Drop: second shadow write overwrites the first
        cyc(1, 32'h00000055, 0, 0);
        cyc(0, 0, 1, 32'h0000000A);
        chk("drop_first", 32'(drop), 0);
        cyc(0, 0, 1, 32'h0000000B);
        chk("drop_second", 32'(drop), 1);
        idle(1);
        chk("drop_pulse_end", 32'(drop), 0);
        idle(1);
        out("drop_exp", 1, 32'h0000000B, 2'b10, 0);
        idle(1);
        chk("drop_we_once", 32'(seg_we), 0);
        idle(2);
        chk("drop_own1", 32'(owner), 32'h2);
        idle(1);
        out("drop_idle", 0, 32'h0000000B, 2'b00, 0);

        // Boundary: req0 on the expiry cycle refreshes ownership
        cyc(1, 32'h00000100, 0, 0);
        idle(3);
        cyc(1, 32'h00000200, 0, 0);
        out("bnd0_refresh", 1, 32'h00000200, 2'b01, 0);
        idle(3);
        chk("bnd0_reload", 32'(owner), 32'h1);
        idle(1);
        chk("bnd0_idle", 32'(owner), 0);

        // Boundary: req1 on the expiry cycle bypasses the stale shadow
        cyc(1, 32'h00000300, 0, 0);
        cyc(0, 0, 1, 32'h00000A0A);
        idle(2);
        cyc(0, 0, 1, 32'h00000B0B);
        out("bnd1_direct", 1, 32'h00000B0B, 2'b10, 0);
        idle(4);
        out("bnd1_idle", 0, 32'h00000B0B, 2'b00, 0);
        // The stale shadow must be gone: next OWN0 expiry goes idle, no write
        cyc(1, 32'h00000400, 0, 0);
        idle(4);
        out("bnd1_noshadow", 0, 32'h00000400, 2'b00, 0);

        // Async reset mid-ownership with a pending shadow
        cyc(1, 32'h00000777, 0, 0);
        cyc(0, 0, 1, 32'h00000888);
        @(negedge clk);
        rst = 1'b1;
        #1;
        out("midrst", 0, 0, 2'b00, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        out("midrst_rel", 0, 0, 2'b00, 0);
        idle(2);
        chk("midrst_nowe", 32'(seg_we), 0);
        // Shadow cleared by reset: OWN0 expires to IDLE, never writes 888
        cyc(1, 32'h00000999, 0, 0);
        idle(4);
        out("midrst_noshadow", 0, 32'h00000999, 2'b00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the single 8-digit seven-segment display between two write requesters:
- Requester 0: CPU MMIO store path, priority.
- Requester 1: debug source, e.g. PC/trace snapshot.

It grants timed ownership to one requester, holds a one-entry shadow for the loser, and drives the display block's write-enable/write-data pair (seg_we/seg_wdata), so the two sources never interleave visibly.

Parameters:
HOLD_CYCLES, 50000000, ownership hold time in clk cycles after the owner's last write; must be >= 1
CNT_W, $clog2(HOLD_CYCLES+1), hold counter width (derived; not overridden)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
req0  input  1  requester 0 write strobe, single-cycle, sampled every posedge
data0  input  32  requester 0 display word, 8 nibbles, digit 0 = bits [3:0]
req1  input  1  requester 1 write strobe, single-cycle
data1  input  32  requester 1 display word
seg_we  output  1  registered one-cycle write pulse to the display block
seg_wdata  output  32  registered write data to the display block
owner  output  2  one-hot current owner {own1, own0}; 2'b00 = idle
drop  output  1  one-cycle pulse: a pending shadow value was overwritten before display

Behaviour:
- Reset (async, any time including mid-ownership):
  - state=IDLE, owner=00, seg_we=0, seg_wdata=0, drop=0, cnt=0.
  - pend0=pend1=0, shadow0=shadow1=0.
  - No write is emitted on reset release.
- All outputs are registered. A request sampled at edge E produces seg_we=1 with its data during the cycle after E (latency 1). seg_we is never high for more than one cycle per accepted write.
- States: IDLE, OWN0, OWN1; owner mirrors state. i denotes the current owner, j the other requester.
- IDLE:
  - req0 (with or without req1) -> OWN0, write data0, cnt<=HOLD_CYCLES-1.
  - If req1 is also high in that cycle: shadow1<=data1, pend1<=1.
  - req1 alone -> OWN1, write data1, cnt reload.
  - No req -> stay, seg_we=0.
- OWN_i, req_i high -> write data_i, cnt reload, stay. This takes precedence over expiry in the same cycle.
- OWN_i, req_j high:
  - shadow_j<=data_j, pend_j<=1.
  - drop=1 if pend_j was already 1.
  - No write is emitted unless expiry also occurs this cycle (see below).
- OWN_i, no req_i, cnt!=0 -> cnt<=cnt-1. Ownership therefore lasts exactly HOLD_CYCLES cycles after the last owner write.
- Expiry (OWN_i, no req_i, cnt==0):
  - If req_j high this cycle -> OWN_j, write data_j directly (newest wins), pend_j<=0, cnt reload, drop=0.
  - Else if pend_j -> OWN_j, write shadow_j, pend_j<=0, cnt reload.
  - Else -> IDLE, no write.
- pend_i is never set while i owns the display; only the non-owner's shadow is used.
- seg_wdata holds its last written value when seg_we=0.
- HOLD_CYCLES=1: ownership expires on the first idle cycle after a write.

Decomposition:
- Shared package (seg_arb_pkg):
  - State encodings ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2.
  - Requester indices REQ_CPU=0, REQ_DBG=1.
  - Data width constant SEG_DW=32.
- One sub-module is natural: seg_req_slot, instantiated once per requester. It holds the shadow register, pend bit and drop detection, with inputs set, clear, and data.
- Top level keeps the FSM, hold counter and output registers.

Test Plan (HOLD_CYCLES=4):
- Reset check: assert rst mid-cycle -> seg_we=0, seg_wdata=0, owner=00, drop=0 immediately. No seg_we after release.
- Single write: req0 with data0=32'h12345678 at edge E -> seg_we=1, seg_wdata=32'h12345678 in cycle E+1, owner=01. owner returns to 00 at edge E+4.
- Collision: req1 data1=32'hDEAD0001 while OWN0 -> no seg_we. On expiry, 4 cycles after the last req0, seg_we=1 with 32'hDEAD0001 and owner=10.
- Simultaneous requests in IDLE: req0=32'h00000011 and req1=32'h00000022 -> first write 32'h11, owner=01. Four cycles later, write 32'h22, owner=10.
- Drop: two req1 strobes (32'hA, then 32'hB) while OWN0 -> drop pulses once, on the second strobe. After expiry only 32'hB is written.
- Boundary: req0 exactly on the expiry cycle -> stays OWN0, writes data0, counter reloads. A req1 arriving on the expiry cycle is written directly, bypassing the stale shadow.
